// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared types and encodings for the multicycle MIPS control unit
// Holds the FSM state enum, instruction classes, opcode/funct constants and
// the aluop, pcsrc, alusrcb, regdst, regvalue and cause encodings.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_MULDIV = 4'd10,
        S_EXCEPT = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        IC_UNDEF, IC_LOAD, IC_STORE, IC_RTYPE, IC_ITYPE,
        IC_JR, IC_MULDIV, IC_BRANCH, IC_JUMP, IC_JAL
    } iclass_t;

    typedef enum logic [1:0] {BR_EQ, BR_NE, BR_GE, BR_LT} brkind_t;

    // Opcodes; bge/bl reuse the blez/bgtz slots of the classic map.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BL    = 6'h06;
    localparam logic [5:0] OP_BGE   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;
    localparam logic [1:0] PCSRC_EXC  = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [2:0] RV_ALU = 3'b000;
    localparam logic [2:0] RV_MEM = 3'b001;
    localparam logic [2:0] RV_PC  = 3'b010;

    localparam logic [1:0] MSZ_NONE = 2'b00;
    localparam logic [1:0] MSZ_BYTE = 2'b01;
    localparam logic [1:0] MSZ_HALF = 2'b10;
    localparam logic [1:0] MSZ_WORD = 2'b11;

    localparam logic [1:0] CAUSE_UNDEF = 2'b00;
    localparam logic [1:0] CAUSE_OVF   = 2'b01;
    localparam logic [1:0] CAUSE_BUS   = 2'b10;

endpackage

// File: rtl/mips_mc_opdec.sv
// rtl/mips_mc_opdec.sv - combinational op/funct decoder for the multicycle control unit
// Ports: op, funct (instruction fields) in; iclass (dispatch class), alu_op,
// mem_size (store size), mem_sign (load sign-extend), br_kind, ovf_chk
// (instruction traps on signed overflow) out.
module mips_mc_opdec
    import mips_mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [3:0] alu_op,
    output logic [1:0] mem_size,
    output logic       mem_sign,
    output brkind_t    br_kind,
    output logic       ovf_chk
);

    always_comb begin
        iclass   = IC_UNDEF;
        alu_op   = ALU_ADD;
        mem_size = MSZ_NONE;
        mem_sign = 1'b0;
        br_kind  = BR_EQ;
        ovf_chk  = 1'b0;
        case (op)
            OP_RTYPE: begin
                iclass = IC_RTYPE;
                case (funct)
                    FN_ADD:  ovf_chk = 1'b1;
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB:  begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_JR:   iclass = IC_JR;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: iclass = IC_MULDIV;
                    default: iclass = IC_UNDEF;
                endcase
            end
            OP_LW:           iclass = IC_LOAD;
            OP_LH, OP_LB:    begin iclass = IC_LOAD; mem_sign = 1'b1; end
            OP_LHU, OP_LBU:  iclass = IC_LOAD;
            OP_SW:           begin iclass = IC_STORE; mem_size = MSZ_WORD; end
            OP_SH:           begin iclass = IC_STORE; mem_size = MSZ_HALF; end
            OP_SB:           begin iclass = IC_STORE; mem_size = MSZ_BYTE; end
            OP_ADDI:         begin iclass = IC_ITYPE; ovf_chk = 1'b1; end
            OP_ADDIU:        iclass = IC_ITYPE;
            OP_SLTI:         begin iclass = IC_ITYPE; alu_op = ALU_SLT; end
            OP_SLTIU:        begin iclass = IC_ITYPE; alu_op = ALU_SLTU; end
            OP_ANDI:         begin iclass = IC_ITYPE; alu_op = ALU_AND; end
            OP_ORI:          begin iclass = IC_ITYPE; alu_op = ALU_OR; end
            OP_XORI:         begin iclass = IC_ITYPE; alu_op = ALU_XOR; end
            OP_LUI:          begin iclass = IC_ITYPE; alu_op = ALU_LUI; end
            OP_BEQ:          begin iclass = IC_BRANCH; br_kind = BR_EQ; end
            OP_BNE:          begin iclass = IC_BRANCH; br_kind = BR_NE; end
            OP_BGE:          begin iclass = IC_BRANCH; br_kind = BR_GE; end
            OP_BL:           begin iclass = IC_BRANCH; br_kind = BR_LT; end
            OP_J:            iclass = IC_JUMP;
            OP_JAL:          iclass = IC_JAL;
            default:         iclass = IC_UNDEF;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS control FSM with memory wait/timeout and muldiv sequencing
// Ports: clk, reset (sync, active-high); op/funct from the IR; ALU flags
// zero/lt/overflow; mem_ready handshake. Outputs drive the datapath muxes and
// enables, the memory request, md_start, EPC/Cause writes and state_dbg.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int MEM_TIMEOUT   = 0,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       lt,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic [1:0] memwrite,
    output logic       memsign,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluop,
    output logic [1:0] regdst,
    output logic [2:0] regvalue,
    output logic       regwrite,
    output logic       md_start,
    output logic       epcwrite,
    output logic       causewrite,
    output logic [1:0] cause,
    output logic [3:0] state_dbg
);

    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MULDIV_CYCLES - 1);
    localparam bit               TO_EN   = (MEM_TIMEOUT > 0);
    // Timeout fires on the wait cycle that would take the count to MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             mem_wait, cnt_inc;

    iclass_t    iclass;
    logic [3:0] alu_op;
    logic [1:0] mem_size;
    logic       mem_sign;
    brkind_t    br_kind;
    logic       ovf_chk;

    mips_mc_opdec u_opdec (
        .op       (op),
        .funct    (funct),
        .iclass   (iclass),
        .alu_op   (alu_op),
        .mem_size (mem_size),
        .mem_sign (mem_sign),
        .br_kind  (br_kind),
        .ovf_chk  (ovf_chk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= CAUSE_UNDEF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        mem_wait   = 1'b0;
        cnt_inc    = 1'b0;
        mem_req    = 1'b0;
        memwrite   = MSZ_NONE;
        memsign    = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = PCSRC_ALU;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        aluop      = ALU_ADD;
        regdst     = RD_RT;
        regvalue   = RV_ALU;
        regwrite   = 1'b0;
        md_start   = 1'b0;
        epcwrite   = 1'b0;
        causewrite = 1'b0;
        cause      = CAUSE_UNDEF;
        state_dbg  = 4'd0;

        if (reset) begin
            // Everything held quiet in the reset cycle; PC+4 select is the idle value.
            alusrcb = SRCB_FOUR;
        end else begin
            state_dbg = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    alusrcb  = SRCB_FOUR;
                    mem_wait = 1'b1;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcen    = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alusrcb = SRCB_IMMSH;
                    case (iclass)
                        IC_LOAD, IC_STORE:                    state_d = S_MEMADR;
                        IC_RTYPE, IC_ITYPE, IC_JR, IC_MULDIV: state_d = S_EXEC;
                        IC_BRANCH:                            state_d = S_BRANCH;
                        IC_JUMP, IC_JAL:                      state_d = S_JUMP;
                        default: begin
                            state_d = S_EXCEPT;
                            cause_d = CAUSE_UNDEF;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                    state_d = (iclass == IC_STORE) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    mem_wait = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = mem_size;
                    mem_wait = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    regvalue = RV_MEM;
                    memsign  = mem_sign;
                    state_d  = S_FETCH;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    alusrcb = (iclass == IC_ITYPE) ? SRCB_IMM : SRCB_RT;
                    aluop   = alu_op;
                    if (iclass == IC_JR) begin
                        // rs + $0 through the ALU straight into the PC.
                        pcen    = 1'b1;
                        aluop   = ALU_ADD;
                        state_d = S_FETCH;
                    end else if (iclass == IC_MULDIV) begin
                        md_start = 1'b1;
                        state_d  = S_MULDIV;
                    end else if (ovf_chk && overflow) begin
                        state_d = S_EXCEPT;
                        cause_d = CAUSE_OVF;
                    end else begin
                        state_d = S_ALUWB;
                    end
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = (iclass == IC_RTYPE) ? RD_RD : RD_RT;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = ALU_SUB;
                    pcsrc   = PCSRC_OUT;
                    case (br_kind)
                        BR_EQ:   pcen = zero;
                        BR_NE:   pcen = !zero;
                        BR_GE:   pcen = !lt;
                        default: pcen = lt;
                    endcase
                    state_d = S_FETCH;
                end
                S_JUMP: begin
                    pcen  = 1'b1;
                    pcsrc = PCSRC_JMP;
                    if (iclass == IC_JAL) begin
                        regwrite = 1'b1;
                        regdst   = RD_R31;
                        regvalue = RV_PC;
                    end
                    state_d = S_FETCH;
                end
                S_MULDIV: begin
                    cnt_inc = 1'b1;
                    if (cnt_q == MD_LAST) state_d = S_FETCH;
                end
                S_EXCEPT: begin
                    epcwrite   = 1'b1;
                    causewrite = 1'b1;
                    pcen       = 1'b1;
                    pcsrc      = PCSRC_EXC;
                    cause      = cause_q;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase

            // mem_ready is excluded here, so a late ready on the last cycle still wins.
            if (mem_wait && !mem_ready) begin
                cnt_inc = 1'b1;
                if (TO_EN && cnt_q == TO_LAST) begin
                    state_d = S_EXCEPT;
                    cause_d = CAUSE_BUS;
                end
            end

            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (cnt_inc && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - directed self-checking bench for mips_mc_ctrl
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset, zero, lt, overflow, mem_ready;
    logic [5:0] op, funct;
    logic       mem_req, memsign, iord, irwrite, pcen, alusrca, regwrite;
    logic       md_start, epcwrite, causewrite;
    logic [1:0] memwrite, pcsrc, alusrcb, regdst, cause;
    logic [3:0] aluop, state_dbg;
    logic [2:0] regvalue;

    int checks = 0;
    int errors = 0;
    int ir_cnt, rw_cnt, md_cnt, n;

    logic [3:0] exp_lw [11] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    logic [5:0] br_op  [4]  = '{6'h04, 6'h05, 6'h07, 6'h06};
    logic       br_z   [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       br_exp [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    mips_mc_ctrl #(.MULDIV_CYCLES(4), .MEM_TIMEOUT(5), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .lt(lt),
        .overflow(overflow), .mem_ready(mem_ready), .mem_req(mem_req),
        .memwrite(memwrite), .memsign(memsign), .iord(iord), .irwrite(irwrite),
        .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .regdst(regdst), .regvalue(regvalue), .regwrite(regwrite),
        .md_start(md_start), .epcwrite(epcwrite), .causewrite(causewrite),
        .cause(cause), .state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: load the instruction fields and complete the fetch, landing in DECODE.
    task automatic to_decode(input logic [5:0] o, input logic [5:0] f);
        op = o;
        funct = f;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; lt = 1'b0;
        overflow = 1'b0; mem_ready = 1'b0;
        tick();
        chk("rst_state",   32'(state_dbg), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_alusrcb", 32'(alusrcb), 32'd1);
        chk("rst_pcen",    32'(pcen), 32'd0);
        reset = 1'b0;
        #1;
        chk("fetch_mem_req", 32'(mem_req), 32'd1);

        // lw with 3 wait cycles in both FETCH and MEMRD
        op = 6'h23; funct = '0; ir_cnt = 0; rw_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            mem_ready = (i == 3 || i == 9);
            #1;
            chk($sformatf("lw_state%0d", i), 32'(state_dbg), 32'(exp_lw[i]));
            ir_cnt += 32'(irwrite);
            rw_cnt += 32'(regwrite);
            tick();
        end
        mem_ready = 1'b0;
        chk("lw_back_fetch", 32'(state_dbg), 32'd0);
        chk("lw_irwrite_cnt", 32'(ir_cnt), 32'd1);
        chk("lw_regwrite_cnt", 32'(rw_cnt), 32'd1);

        // add with overflow
        to_decode(6'h00, 6'h20);
        chk("add_decode", 32'(state_dbg), 32'd1);
        tick();
        overflow = 1'b1;
        #1;
        chk("add_exec", 32'(state_dbg), 32'd6);
        chk("add_exec_regwrite", 32'(regwrite), 32'd0);
        tick();
        overflow = 1'b0;
        chk("ovf_state", 32'(state_dbg), 32'd11);
        chk("ovf_cause", 32'(cause), 32'd1);
        chk("ovf_epcwrite", 32'(epcwrite), 32'd1);
        chk("ovf_causewrite", 32'(causewrite), 32'd1);
        chk("ovf_regwrite", 32'(regwrite), 32'd0);
        chk("ovf_pcsrc", 32'(pcsrc), 32'd3);
        tick();
        chk("ovf_back_fetch", 32'(state_dbg), 32'd0);

        // undefined opcode
        to_decode(6'h3f, 6'h00);
        tick();
        chk("undef_state", 32'(state_dbg), 32'd11);
        chk("undef_cause", 32'(cause), 32'd0);
        chk("undef_pcen", 32'(pcen), 32'd1);
        chk("undef_pcsrc", 32'(pcsrc), 32'd3);
        tick();

        // beq/bne/bge/bl pcen
        for (int i = 0; i < 4; i++) begin
            to_decode(br_op[i], 6'h00);
            tick();
            zero = br_z[i];
            lt = 1'b0;
            #1;
            chk($sformatf("br%0d_state", i), 32'(state_dbg), 32'd8);
            chk($sformatf("br%0d_pcen", i), 32'(pcen), 32'(br_exp[i]));
            tick();
            zero = 1'b0;
        end

        // mult: one md_start, 4 MULDIV cycles
        to_decode(6'h00, 6'h18);
        tick();
        chk("mult_exec", 32'(state_dbg), 32'd6);
        chk("mult_md_start", 32'(md_start), 32'd1);
        md_cnt = 32'(md_start);
        tick();
        n = 0;
        while (state_dbg == 4'd10 && n < 20) begin
            md_cnt += 32'(md_start);
            n++;
            tick();
        end
        chk("muldiv_cycles", 32'(n), 32'd4);
        chk("md_start_cnt", 32'(md_cnt), 32'd1);
        chk("mult_back_fetch", 32'(state_dbg), 32'd0);

        // jal
        to_decode(6'h03, 6'h00);
        tick();
        chk("jal_state", 32'(state_dbg), 32'd9);
        chk("jal_regwrite", 32'(regwrite), 32'd1);
        chk("jal_regdst", 32'(regdst), 32'd2);
        chk("jal_regvalue", 32'(regvalue), 32'd2);
        chk("jal_pcsrc", 32'(pcsrc), 32'd2);
        tick();

        // sw
        to_decode(6'h2b, 6'h00);
        tick();
        tick();
        chk("sw_state", 32'(state_dbg), 32'd5);
        chk("sw_memwrite", 32'(memwrite), 32'd3);
        chk("sw_iord", 32'(iord), 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("sw_back_fetch", 32'(state_dbg), 32'd0);

        // memory timeout in MEMRD
        to_decode(6'h23, 6'h00);
        tick();
        tick();
        n = 0;
        while (state_dbg == 4'd3 && n < 20) begin
            n++;
            tick();
        end
        chk("to_wait_cycles", 32'(n), 32'd5);
        chk("to_state", 32'(state_dbg), 32'd11);
        chk("to_cause", 32'(cause), 32'd2);
        chk("to_mem_req", 32'(mem_req), 32'd0);
        tick();

        // reset mid-MEMRD
        to_decode(6'h23, 6'h00);
        tick();
        tick();
        chk("rmid_state", 32'(state_dbg), 32'd3);
        reset = 1'b1;
        #1;
        chk("rmid_regwrite", 32'(regwrite), 32'd0);
        chk("rmid_memwrite", 32'(memwrite), 32'd0);
        chk("rmid_irwrite", 32'(irwrite), 32'd0);
        chk("rmid_pcen", 32'(pcen), 32'd0);
        chk("rmid_epcwrite", 32'(epcwrite), 32'd0);
        chk("rmid_causewrite", 32'(causewrite), 32'd0);
        chk("rmid_mem_req", 32'(mem_req), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rmid_fetch", 32'(state_dbg), 32'd0);
        chk("rmid_fetch_req", 32'(mem_req), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
